// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master among NREQ requesters, one transfer per grant.
// Define APB_ARB_TIMEOUT_EN to compile in the BUSY watchdog (abort after TIMEOUT-1 BUSY cycles).
module apb_req_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_rw,
  input  logic [33*NREQ-1:0]  req_addr,
  input  logic [32*NREQ-1:0]  req_wdata,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic [31:0]         rdata,
  output logic                transfer,
  output logic                Read_write,
  output logic [32:0]         write_addr,
  output logic [32:0]         read_addr,
  output logic [31:0]         write_data,
  input  logic                m_penable,
  input  logic                m_pready,
  input  logic                m_slverr,
  input  logic [31:0]         m_readout
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned AW = 33;
  localparam int unsigned DW = 32;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [NREQ-1:0] gnt_nxt, done_nxt;
  logic            err_nxt, transfer_nxt, rw_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [DW-1:0]   rdata_nxt, wdata_nxt;
  logic [IW-1:0]   sel;
  logic            sel_vld;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CW = 8;
  logic [CW-1:0] cnt, cnt_nxt;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  // First requester at or after ptr, wrapping at NREQ
  always_comb begin
    int unsigned pos;
    pos     = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = (32'(ptr) + i) % NREQ;
      if (!sel_vld && req[IW'(pos)]) begin
        sel     = IW'(pos);
        sel_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    idx_nxt      = idx;
    gnt_nxt      = gnt;
    done_nxt     = '0;
    err_nxt      = 1'b0;
    rdata_nxt    = rdata;
    transfer_nxt = transfer;
    rw_nxt       = Read_write;
    addr_nxt     = write_addr;
    wdata_nxt    = write_data;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_nxt      = cnt;
`endif
    case (state)
      S_IDLE: begin
        if (sel_vld) begin
          state_nxt    = S_BUSY;
          idx_nxt      = sel;
          gnt_nxt      = NREQ'(1) << sel;
          transfer_nxt = 1'b1;
          rw_nxt       = req_rw[sel];
          addr_nxt     = req_addr[AW*32'(sel) +: AW];
          wdata_nxt    = req_wdata[DW*32'(sel) +: DW];
`ifdef APB_ARB_TIMEOUT_EN
          cnt_nxt      = '0;
`endif
        end
      end
      S_BUSY: begin
        // Slave error wins over a same-cycle completion
        if (m_slverr) begin
          done_nxt = gnt;
          err_nxt  = 1'b1;
        end else if (m_penable && m_pready) begin
          done_nxt = gnt;
          if (!Read_write) rdata_nxt = m_readout;
        end else begin
`ifdef APB_ARB_TIMEOUT_EN
          cnt_nxt = cnt + 1'b1;
          if (cnt_nxt == CW'(TIMEOUT - 1)) begin
            done_nxt = gnt;
            err_nxt  = 1'b1;
          end
`endif
        end
        if (done_nxt != '0) begin
          state_nxt    = S_RELEASE;
          gnt_nxt      = '0;
          transfer_nxt = 1'b0;
        end
      end
      S_RELEASE: begin
        state_nxt = S_IDLE;
        ptr_nxt   = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      ptr        <= '0;
      idx        <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      rdata      <= '0;
      transfer   <= 1'b0;
      Read_write <= 1'b0;
      write_addr <= '0;
      read_addr  <= '0;
      write_data <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      ptr        <= ptr_nxt;
      idx        <= idx_nxt;
      gnt        <= gnt_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      rdata      <= rdata_nxt;
      transfer   <= transfer_nxt;
      Read_write <= rw_nxt;
      write_addr <= addr_nxt;
      read_addr  <= addr_nxt;
      write_data <= wdata_nxt;
`ifdef APB_ARB_TIMEOUT_EN
      cnt        <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small APB master model (SETUP/ACCESS, programmable wait states).
module tb_apb_req_arbiter;

  localparam int unsigned NREQ = 4;

  logic            pclk, preset;
  logic [3:0]      req, req_rw;
  logic [131:0]    req_addr;
  logic [127:0]    req_wdata;
  logic [3:0]      gnt, done;
  logic            err, transfer, Read_write;
  logic [31:0]     rdata, write_data;
  logic [32:0]     write_addr, read_addr;
  logic            m_penable, m_pready, m_slverr;
  logic [31:0]     m_readout;

  logic [1:0]      mst;
  logic [3:0]      wcnt;
  int              wait_states;
  logic            pready_en, slverr_force;
  logic [31:0]     readout_val;

  int total = 0;
  int bad   = 0;

  apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .transfer(transfer), .Read_write(Read_write), .write_addr(write_addr),
    .read_addr(read_addr), .write_data(write_data), .m_penable(m_penable),
    .m_pready(m_pready), .m_slverr(m_slverr), .m_readout(m_readout)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Master model: IDLE -> SETUP -> ACCESS (wait_states cycles of pready low) -> IDLE
  always @(posedge pclk or negedge preset) begin
    if (!preset) begin
      mst  <= 2'd0;
      wcnt <= 4'd0;
    end else begin
      case (mst)
        2'd0: if (transfer) mst <= 2'd1;
        2'd1: begin mst <= 2'd2; wcnt <= 4'(wait_states); end
        default: begin
          if (m_pready) mst <= 2'd0;
          else if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
        end
      endcase
    end
  end
  assign m_penable = (mst == 2'd2);
  assign m_pready  = m_penable && pready_en && (wcnt == 4'd0);
  assign m_slverr  = m_penable && slverr_force;
  assign m_readout = readout_val;

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset;
    preset = 1'b0;
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    wait_states = 0; pready_en = 1'b1; slverr_force = 1'b0; readout_val = '0;
    tick;
    tick;
    preset = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    preset = 1'b0;
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    wait_states = 0; pready_en = 1'b1; slverr_force = 1'b0; readout_val = '0;
    tick;
    total++;
    if ({gnt, done, err, transfer} !== 10'b0) begin
      bad++; $display("FAIL reset_ctrl got gnt=%b done=%b err=%b transfer=%b want 0", gnt, done, err, transfer);
    end
    total++;
    if ({rdata, write_data, write_addr, read_addr, Read_write} !== 131'b0) begin
      bad++; $display("FAIL reset_data got rdata=%h wdata=%h waddr=%h raddr=%h rw=%b want 0",
                      rdata, write_data, write_addr, read_addr, Read_write);
    end
    preset = 1'b1;
    tick;
    total++;
    if (gnt !== 4'b0 || transfer !== 1'b0) begin
      bad++; $display("FAIL idle_no_req got gnt=%b transfer=%b want 0 0", gnt, transfer);
    end
  endtask

  task automatic test_single_write;
    req_rw[0] = 1'b1;
    req_addr[32:0] = 33'h0_0000_0010;
    req_wdata[31:0] = 32'hA5A5_A5A5;
    wait_states = 0;
    req[0] = 1'b1;
    tick;
    total++;
    if (gnt !== 4'b0001 || transfer !== 1'b1 || Read_write !== 1'b1) begin
      bad++; $display("FAIL wr_grant got gnt=%b transfer=%b rw=%b want 0001 1 1", gnt, transfer, Read_write);
    end
    total++;
    if (write_addr !== 33'h10 || read_addr !== 33'h10 || write_data !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL wr_cmd got waddr=%h raddr=%h wdata=%h want 10 10 a5a5a5a5", write_addr, read_addr, write_data);
    end
    // Requester inputs change mid-transaction; master side must not follow
    req_wdata[31:0] = 32'h0;
    req_rw[0] = 1'b0;
    req_addr[32:0] = 33'h0_0000_01FF;
    tick;
    tick;
    total++;
    if (transfer !== 1'b1 || done !== 4'b0) begin
      bad++; $display("FAIL wr_busy got transfer=%b done=%b want 1 0000", transfer, done);
    end
    tick;
    total++;
    if (done !== 4'b0001 || err !== 1'b0 || transfer !== 1'b0 || gnt !== 4'b0) begin
      bad++; $display("FAIL wr_done got done=%b err=%b transfer=%b gnt=%b want 0001 0 0 0000", done, err, transfer, gnt);
    end
    total++;
    if (write_data !== 32'hA5A5_A5A5 || Read_write !== 1'b1 || write_addr !== 33'h10 || rdata !== 32'h0) begin
      bad++; $display("FAIL wr_hold got wdata=%h rw=%b waddr=%h rdata=%h want a5a5a5a5 1 10 0",
                      write_data, Read_write, write_addr, rdata);
    end
    req[0] = 1'b0;
    tick;
    total++;
    if (done !== 4'b0 || gnt !== 4'b0) begin
      bad++; $display("FAIL wr_pulse got done=%b gnt=%b want 0000 0000", done, gnt);
    end
  endtask

  task automatic test_read_wait;
    int n;
    req_rw[2] = 1'b0;
    req_addr[98:66] = 33'h0_0000_0020;
    wait_states = 2;
    readout_val = 32'h1234_5678;
    req[2] = 1'b1;
    tick;
    n = 1;
    total++;
    if (gnt !== 4'b0100 || Read_write !== 1'b0 || read_addr !== 33'h20) begin
      bad++; $display("FAIL rd_grant got gnt=%b rw=%b raddr=%h want 0100 0 20", gnt, Read_write, read_addr);
    end
    while (done == 4'b0 && n < 20) begin
      tick;
      n++;
    end
    total++;
    if (n !== 6) begin
      bad++; $display("FAIL rd_latency got %0d cycles want 6", n);
    end
    total++;
    if (done !== 4'b0100 || err !== 1'b0 || rdata !== 32'h1234_5678) begin
      bad++; $display("FAIL rd_done got done=%b err=%b rdata=%h want 0100 0 12345678", done, err, rdata);
    end
    req[2] = 1'b0;
    wait_states = 0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] prev;
    int n, gap, over;
    do_reset;
    req_rw = 4'hF;
    req = 4'hF;
    prev = '0; n = 0; gap = 0; over = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      tick;
      if ($countones(gnt) > 1) over++;
      if (gnt != 4'b0 && prev == 4'b0) begin
        total++;
        if (gnt !== exp_g[n]) begin
          bad++; $display("FAIL rr_order#%0d got gnt=%b want %b", n, gnt, exp_g[n]);
        end
        if (n > 0) begin
          total++;
          if (gap !== 2) begin
            bad++; $display("FAIL rr_gap#%0d got %0d idle cycles want 2", n, gap);
          end
        end
        n++;
        gap = 0;
      end else if (gnt == 4'b0) begin
        gap++;
      end
      prev = gnt;
    end
    total++;
    if (n !== 5 || over !== 0) begin
      bad++; $display("FAIL rr_count got grants=%0d overlaps=%0d want 5 0", n, over);
    end
    req = '0;
  endtask

  task automatic test_error;
    int n;
    do_reset;
    readout_val = 32'hDEAD_BEEF;
    slverr_force = 1'b1;
    req_rw[1] = 1'b0;
    req_addr[65:33] = 33'h1_0000_0040;
    req_rw[2] = 1'b0;
    req_addr[98:66] = 33'h0_0000_0080;
    req = 4'b0110;
    n = 0;
    while (done == 4'b0 && n < 20) begin
      tick;
      n++;
    end
    total++;
    if (done !== 4'b0010 || err !== 1'b1 || rdata !== 32'h0) begin
      bad++; $display("FAIL err_abort got done=%b err=%b rdata=%h want 0010 1 0", done, err, rdata);
    end
    total++;
    if (write_addr !== 33'h1_0000_0040) begin
      bad++; $display("FAIL err_addr got waddr=%h want 100000040", write_addr);
    end
    req[1] = 1'b0;
    slverr_force = 1'b0;
    tick;
    total++;
    if (done !== 4'b0 || err !== 1'b0) begin
      bad++; $display("FAIL err_pulse got done=%b err=%b want 0000 0", done, err);
    end
    n = 0;
    while (gnt == 4'b0 && n < 10) begin
      tick;
      n++;
    end
    total++;
    if (gnt !== 4'b0100) begin
      bad++; $display("FAIL err_next got gnt=%b want 0100", gnt);
    end
    n = 0;
    while (done == 4'b0 && n < 20) begin
      tick;
      n++;
    end
    total++;
    if (done !== 4'b0100 || err !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL err_next_done got done=%b err=%b rdata=%h want 0100 0 deadbeef", done, err, rdata);
    end
    req = '0;
    tick;
  endtask

  task automatic test_stall;
    int n;
    do_reset;
    pready_en = 1'b0;
    req_rw[3] = 1'b1;
    req[3] = 1'b1;
    tick;
    n = 1;
`ifdef APB_ARB_TIMEOUT_EN
    while (done == 4'b0 && n < 40) begin
      tick;
      n++;
    end
    total++;
    if (n !== 16 || done !== 4'b1000 || err !== 1'b1) begin
      bad++; $display("FAIL timeout got cycles=%0d done=%b err=%b want 16 1000 1", n, done, err);
    end
`else
    for (int c = 0; c < 100; c++) begin
      tick;
      if (done != 4'b0) n = -1000;
    end
    total++;
    if (n < 0 || transfer !== 1'b1 || gnt !== 4'b1000) begin
      bad++; $display("FAIL stall got early_done=%0d transfer=%b gnt=%b want 0 1 1000", n < 0, transfer, gnt);
    end
`endif
    req = '0;
  endtask

  task automatic test_async_reset;
    do_reset;
    pready_en = 1'b0;
    req_rw = 4'hF;
    req_addr[131:99] = 33'h0_0000_0ABC;
    req_wdata[127:96] = 32'h5555_AAAA;
    req = 4'b1000;
    tick;
    tick;
    tick;
    total++;
    if (transfer !== 1'b1 || gnt !== 4'b1000 || write_data !== 32'h5555_AAAA) begin
      bad++; $display("FAIL ar_pre got transfer=%b gnt=%b wdata=%h want 1 1000 5555aaaa", transfer, gnt, write_data);
    end
    preset = 1'b0;
    #2;
    total++;
    if ({gnt, done, err, rdata, transfer, Read_write, write_addr, read_addr, write_data} !== 141'b0) begin
      bad++; $display("FAIL ar_async got gnt=%b transfer=%b rw=%b waddr=%h wdata=%h want all 0",
                      gnt, transfer, Read_write, write_addr, write_data);
    end
    req = 4'b1010;
    pready_en = 1'b1;
    tick;
    preset = 1'b1;
    tick;
    total++;
    if (gnt !== 4'b0010) begin
      bad++; $display("FAIL ar_first got gnt=%b want 0010", gnt);
    end
    req = '0;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read_wait;
    test_back_to_back;
    test_error;
    test_stall;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares the single APB master (`apbmaster`) between NREQ local requesters. It captures one requester's command and drives the master's `transfer`/`Read_write`/address/data inputs for exactly one APB transfer. It then reports completion, read data and error back to that requester. It sits between the requester blocks and `apbmaster`; the APB bus itself is untouched.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 16, max cycles in BUSY before forced abort (only with watchdog compiled in)

Ports:
- pclk  in  1  clock; all logic on rising edge
- preset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level; held until matching `done`
- req_rw  in  NREQ  per-requester direction, 0 read, 1 write
- req_addr  in  33*NREQ  per-requester address, slice i = [33i+32:33i]; bit 32 set = unmapped
- req_wdata  in  32*NREQ  per-requester write data
- gnt  out  NREQ  one-hot grant, high for the whole transaction
- done  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse coincident with `done` on error/abort
- rdata  out  32  read data, valid with `done` of a read
- transfer  out  1  to master `transfer`
- Read_write  out  1  to master `Read_write`
- write_addr, read_addr  out  33  to master; both driven with captured address
- write_data  out  32  to master `write_data`
- m_penable  in  1  master `penable`
- m_pready  in  1  slave `pready` as seen by master
- m_slverr  in  1  master `PSlavErr`
- m_readout  in  32  master `readOut`

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: if any `req` high, pick first requester at or after pointer `ptr` (wrap at NREQ). Register `gnt`, capture that requester's rw/addr/wdata into command registers, go BUSY.
- BUSY: `transfer`=1; master inputs driven from command registers (stable whole transaction, independent of later requester input changes).
- Completion: `m_penable & m_pready` sampled high in BUSY. `done[i]`=1 next cycle; `rdata` <= `m_readout` if read, else unchanged; go RELEASE.
- Error: `m_slverr` sampled high in BUSY (takes priority over completion in the same cycle). `done[i]`=1 and `err`=1; `rdata` unchanged; go RELEASE.
- RELEASE: `transfer`=0, `gnt`=0 for one cycle so the master returns to idle. `ptr` <= granted index + 1 mod NREQ, then go IDLE.
- Requester dropping `req` during BUSY does not abort; transaction completes, `done` still pulses.
- Requests arriving during BUSY/RELEASE are considered only in IDLE.

## Timing
- Reset (asynchronous, any state): state IDLE, `ptr`=0, `gnt`=0, `done`=0, `err`=0, `rdata`=0, `transfer`=0, `Read_write`=0, addresses 0, `write_data`=0, timeout counter 0.
- `req` high at edge k in IDLE -> `gnt`, `transfer` high after edge k.
- Master takes SETUP then ACCESS: with `pready` tied high, `done` is asserted 3 cycles after `transfer` rises.
- `done`/`err` are registered pulses, exactly one cycle, asserted on the RELEASE cycle.
- Minimum spacing between grants: 1 RELEASE + 1 IDLE cycle.
- Fairness: with all NREQ requesting continuously, each is granted once per NREQ transactions, order 0,1,..,NREQ-1.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined: an 8-bit counter clears on entry to BUSY and increments each BUSY cycle. When it reaches TIMEOUT-1 without completion or error, the block forces abort: `done`+`err` pulse, RELEASE.
- Undefined: no counter; BUSY waits indefinitely for completion or `m_slverr`.

## Test plan
- Single write: req[0]=1, rw=1, addr=0x00000010, wdata=0xA5A5A5A5, pready=1 -> transfer high for 3 cycles; then `done[0]` pulse, `err`=0, `write_data`=0xA5A5A5A5 held throughout.
- Read: req[2] read addr 0x20, slave returns 0x12345678 with pready after 2 wait states -> `done[2]` pulse, `rdata`=0x12345678.
- All four requesting continuously -> grant order 0,1,2,3,0; no grant overlap; RELEASE gap before each new grant.
- Unmapped address bit32=1 with `m_slverr` forced high -> `done`+`err` same cycle, `rdata` unchanged, next requester then served.
- With `APB_ARB_TIMEOUT_EN`, TIMEOUT=16, pready held 0 -> `err`+`done` pulse after 15 BUSY cycles; without macro, still BUSY at 100 cycles.
- `preset` low mid-BUSY -> all outputs 0 immediately (asynchronous); after release, the first grant goes to the lowest-index requester.
